// File: rtl/steer_en_ctrl.sv
// steer_en_ctrl: rider-detect and steering-enable controller.
// Registers raw left/right load-cell readings, derives sum/difference
// comparisons with hysteresis, and sequences IDLE -> SETTLE -> STEER, with a
// debounced STEPOFF state so short step-off glitches do not drop steering.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   lft_ld     in   left load-cell reading (unsigned, LD_W bits)
//   rght_ld    in   right load-cell reading (unsigned, LD_W bits)
//   en_steer   out  steering enable (STEER or STEPOFF)
//   rider_off  out  no rider detected (IDLE)
//   settling   out  waiting for rider to balance (SETTLE)
//   steer_lost out  one-cycle pulse on the first cycle en_steer is low
module steer_en_ctrl #(
    parameter int unsigned LD_W         = 12,
    parameter int unsigned MIN_RIDER_WT = 12'h200,
    parameter int unsigned HYST         = 12'h40,
    parameter int unsigned SETTLE_CYC   = 65_000_000,
    parameter int unsigned STEPOFF_CYC  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    output logic            en_steer,
    output logic            rider_off,
    output logic            settling,
    output logic            steer_lost
);

    localparam int unsigned SUM_W   = LD_W + 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYC > STEPOFF_CYC) ? SETTLE_CYC : STEPOFF_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SUM_W-1:0] THR_HI       = SUM_W'(MIN_RIDER_WT + HYST);
    localparam logic [SUM_W-1:0] THR_LO       = SUM_W'(MIN_RIDER_WT - HYST);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] STEPOFF_LAST = CNT_W'(STEPOFF_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_STEER   = 2'd2,
        S_STEPOFF = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [LD_W-1:0]   lft_q;
    logic [LD_W-1:0]   rght_q;
    logic              lost_nxt;

    logic [SUM_W-1:0]  sum;
    logic [LD_W-1:0]   diff;
    logic              sum_gt_min;
    logic              sum_lt_min;
    logic              diff_gt_1_4;
    logic              diff_gt_15_16;

    // Load arithmetic on the registered readings
    always_comb begin
        sum           = SUM_W'(lft_q) + SUM_W'(rght_q);
        diff          = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
        sum_gt_min    = sum > THR_HI;
        sum_lt_min    = sum < THR_LO;
        diff_gt_1_4   = SUM_W'(diff) > (sum >> 2);
        diff_gt_15_16 = SUM_W'(diff) > (sum - (sum >> 4));
    end

    // Next-state, shared counter and steer_lost decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lost_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (sum_gt_min) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                end
            end
            S_SETTLE: begin
                if (sum_lt_min) begin
                    state_nxt = S_IDLE;
                end else if (diff_gt_1_4) begin
                    cnt_nxt = '0;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = S_STEER;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_STEER: begin
                if (sum_lt_min) begin
                    state_nxt = S_IDLE;
                    lost_nxt  = 1'b1;
                end else if (diff_gt_15_16) begin
                    // The triggering STEER cycle counts as the first sample
                    state_nxt = S_STEPOFF;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_STEPOFF: begin
                if (sum_lt_min) begin
                    state_nxt = S_IDLE;
                    lost_nxt  = 1'b1;
                end else if (!diff_gt_15_16) begin
                    state_nxt = S_STEER;
                end else if (cnt == STEPOFF_LAST) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                    lost_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, input capture and registered Moore outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lft_q      <= '0;
            rght_q     <= '0;
            en_steer   <= 1'b0;
            rider_off  <= 1'b1;
            settling   <= 1'b0;
            steer_lost <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lft_q      <= lft_ld;
            rght_q     <= rght_ld;
            en_steer   <= (state_nxt == S_STEER) || (state_nxt == S_STEPOFF);
            rider_off  <= (state_nxt == S_IDLE);
            settling   <= (state_nxt == S_SETTLE);
            steer_lost <= lost_nxt;
        end
    end

endmodule

// File: tb/tb_steer_en_ctrl.sv
// tb_steer_en_ctrl: table-driven scoreboard bench for steer_en_ctrl
// (SETTLE_CYC=16, STEPOFF_CYC=4). Each vector drives a load pair for n
// cycles and queues the expected {en_steer,rider_off,settling,steer_lost}
// after each of those edges; a monitor pops and compares after every edge.
module tb_steer_en_ctrl;

    localparam logic [3:0] EN      = 4'b1000;
    localparam logic [3:0] OFF     = 4'b0100;
    localparam logic [3:0] SET     = 4'b0010;
    localparam logic [3:0] LOSTSET = 4'b0011;
    localparam logic [3:0] LOSTOFF = 4'b0101;

    typedef struct {
        logic [11:0] lft;
        logic [11:0] rght;
        int          n;
        logic [3:0]  exp;
    } vec_t;

    typedef struct {
        logic [3:0] o;
        int         tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        en_steer;
    logic        rider_off;
    logic        settling;
    logic        steer_lost;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[$];
    vec_t mid[$];

    steer_en_ctrl #(
        .LD_W(12),
        .MIN_RIDER_WT(12'h200),
        .HYST(12'h40),
        .SETTLE_CYC(16),
        .STEPOFF_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lft_ld(lft_ld),
        .rght_ld(rght_ld),
        .en_steer(en_steer),
        .rider_off(rider_off),
        .settling(settling),
        .steer_lost(steer_lost)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: compare just after each active edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e   = exp_q.pop_front();
            act = {en_steer, rider_off, settling, steer_lost};
            checks++;
            if (act !== e.o) begin
                errors++;
                $display("FAIL vec%0d t=%0t: {en,off,set,lost} got %b expected %b",
                         e.tag, $time, act, e.o);
            end
        end
    end

    function automatic vec_t mk(input logic [11:0] l, input logic [11:0] r,
                                input int n, input logic [3:0] e);
        vec_t v;
        v.lft = l; v.rght = r; v.n = n; v.exp = e;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int tag);
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            lft_ld  = v.lft;
            rght_ld = v.rght;
            exp_q.push_back('{v.exp, tag});
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected results never compared", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] e);
        logic [3:0] act;
        act = {en_steer, rider_off, settling, steer_lost};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s t=%0t: {en,off,set,lost} got %b expected %b", name, $time, act, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Main sequence: mount, step-off debounce, settle restart, hysteresis
        vecs.push_back(mk(12'h180, 12'h180, 1,  OFF));
        vecs.push_back(mk(12'h180, 12'h180, 16, SET));
        vecs.push_back(mk(12'h180, 12'h180, 4,  EN));
        vecs.push_back(mk(12'h2F8, 12'h008, 3,  EN));      // 3 step-off samples: kept
        vecs.push_back(mk(12'h180, 12'h180, 3,  EN));
        vecs.push_back(mk(12'h2F8, 12'h008, 4,  EN));      // 4 samples: dropped
        vecs.push_back(mk(12'h180, 12'h180, 1,  LOSTSET));
        vecs.push_back(mk(12'h180, 12'h180, 3,  SET));
        vecs.push_back(mk(12'h280, 12'h080, 5,  SET));     // imbalance restarts settle
        vecs.push_back(mk(12'h180, 12'h180, 16, SET));
        vecs.push_back(mk(12'h180, 12'h180, 2,  EN));      // 17 edges after last imbalance
        vecs.push_back(mk(12'h110, 12'h110, 4,  EN));      // sum 0x220 in band
        vecs.push_back(mk(12'h0D8, 12'h0D8, 1,  EN));      // sum 0x1B0 below band
        vecs.push_back(mk(12'h0D8, 12'h0D8, 1,  LOSTOFF));
        vecs.push_back(mk(12'h0D8, 12'h0D8, 2,  OFF));
        vecs.push_back(mk(12'h110, 12'h110, 5,  OFF));     // in band from IDLE
        vecs.push_back(mk(12'h120, 12'h120, 3,  OFF));     // sum == upper threshold
        vecs.push_back(mk(12'h121, 12'h120, 1,  OFF));     // one above threshold
        vecs.push_back(mk(12'h121, 12'h120, 2,  SET));
        vecs.push_back(mk(12'h0E0, 12'h0E0, 3,  SET));     // sum == lower threshold
        vecs.push_back(mk(12'h0DF, 12'h0E0, 1,  SET));     // one below threshold
        vecs.push_back(mk(12'h0DF, 12'h0E0, 2,  OFF));

        // Mount to STEER then enter STEPOFF with cnt=2
        mid.push_back(mk(12'h180, 12'h180, 1,  OFF));
        mid.push_back(mk(12'h180, 12'h180, 16, SET));
        mid.push_back(mk(12'h180, 12'h180, 1,  EN));
        mid.push_back(mk(12'h2F8, 12'h008, 3,  EN));

        // Reset asserted between edges takes effect immediately
        #2 rst = 1'b1;
        #1 chk_out("reset_async", OFF);
        repeat (2) @(posedge clk);
        #1 chk_out("reset_hold", OFF);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk_out("reset_release", OFF);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        drain("main_table");

        for (int i = 0; i < mid.size(); i++) apply(mid[i], 100 + i);
        drain("mid_stepoff");

        // Reset mid-STEPOFF: en_steer drops at once, no steer_lost
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_out("rst_stepoff_async", OFF);
        lft_ld  = '0;
        rght_ld = '0;
        repeat (2) @(posedge clk);
        #1 chk_out("rst_stepoff_hold", OFF);
        @(negedge clk) rst = 1'b0;

        // Full settle required again
        apply(mk(12'h180, 12'h180, 1,  OFF), 200);
        apply(mk(12'h180, 12'h180, 16, SET), 201);
        apply(mk(12'h180, 12'h180, 2,  EN),  202);
        drain("resettle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
